// File: rtl/uart_rx_frame_if.sv
// rtl/uart_rx_frame_if.sv - received-word handshake bundle for the UART deframer
//
// Purpose: carries one received word plus its error flags from the deframer
// (master) to the consumer (slave) with a valid/ready transfer.
// Signals:
//   rx_data    word, bit 0 = first data bit on the line
//   rx_valid   rx_data holds an unconsumed word
//   rx_ready   consumer accept; transfer when rx_valid && rx_ready at a clk edge
//   rx_ferr    framing error on the held word
//   rx_perr    parity error on the held word
//   rx_overrun one-clk pulse when a completed frame was dropped
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 rx_ferr;
    logic                 rx_perr;
    logic                 rx_overrun;

    modport master (
        output rx_data,
        output rx_valid,
        output rx_ferr,
        output rx_perr,
        output rx_overrun,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        input  rx_ferr,
        input  rx_perr,
        input  rx_overrun,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - oversampling UART receive deframer with valid/ready output
//
// Purpose: synchronizes rxd, qualifies the start bit at its centre, shifts in
// DATA_BITS data bits LSB-first, checks the stop bit (and parity when the
// UART_RX_PARITY_EN macro is defined) and presents each word on a held output
// register with per-word error flags.
// Ports:
//   clk      system clock, rising edge
//   reset    asynchronous, active-high
//   os_tick  single-cycle strobe at OVERSAMPLE x baud
//   rxd      asynchronous serial line, idles high
//   busy     high whenever the receiver is not idle
//   rx       uart_rx_frame_if master: rx_data/rx_valid/rx_ready/rx_ferr/
//            rx_perr/rx_overrun
// Build option: UART_RX_PARITY_EN adds a parity bit between data and stop;
// without it rx_perr is always 0.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               os_tick,
    input  logic               rxd,
    output logic               busy,
    uart_rx_frame_if.master    rx
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS + 1);

    localparam logic [TW-1:0] LP_TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LP_TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LP_BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic          LP_ODD       = (PARITY_ODD != 0);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
    localparam logic [2:0] S_PARITY    = 3'd3;
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_IDLE = 3'd5;

    logic                 r_rxd_meta;
    logic                 r_rxd_sync;
    logic [2:0]           r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shreg;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_ferr;
    logic                 r_perr;
    logic                 r_overrun;

    logic w_bit_edge;
    logic w_deliver;
    logic w_xfer;
    logic w_perr_word;

    // Bit-centre sample point for DATA, PARITY and STOP.
    assign w_bit_edge = os_tick && (r_tick == LP_TICK_LAST);
    assign w_deliver  = (r_state == S_STOP) && w_bit_edge;
    assign w_xfer     = r_valid && rx.rx_ready;

`ifdef UART_RX_PARITY_EN
    logic r_perr_int;
    assign w_perr_word = r_perr_int;
`else
    // No parity bit on the line, so the parity sense has nothing to act on.
    assign w_perr_word = LP_ODD & 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rxd_meta <= 1'b1;
            r_rxd_sync <= 1'b1;
        end else begin
            r_rxd_meta <= rxd;
            r_rxd_sync <= r_rxd_meta;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shreg <= '0;
`ifdef UART_RX_PARITY_EN
            r_perr_int <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (os_tick && !r_rxd_sync) begin
                        r_state <= S_START;
                        r_tick  <= '0;
                    end
                end
                S_START: begin
                    if (os_tick) begin
                        if (r_tick == LP_TICK_HALF) begin
                            // A glitch shorter than half a bit is a false start.
                            if (r_rxd_sync) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state <= S_DATA;
                                r_tick  <= '0;
                                r_bit   <= '0;
                            end
                        end else begin
                            r_tick <= r_tick + 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (w_bit_edge) begin
                        r_shreg <= {r_rxd_sync, r_shreg[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        r_tick  <= '0;
                        if (r_bit == LP_BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
                            r_state <= S_PARITY;
`else
                            r_state <= S_STOP;
`endif
                        end
                    end else if (os_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_edge) begin
                        r_perr_int <= (^r_shreg) ^ r_rxd_sync ^ LP_ODD;
                        r_tick     <= '0;
                        r_state    <= S_STOP;
                    end else if (os_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_edge) begin
                        r_tick  <= '0;
                        // A low stop bit may be a break; wait for the line to idle.
                        r_state <= r_rxd_sync ? S_IDLE : S_WAIT_IDLE;
                    end else if (os_tick) begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                S_WAIT_IDLE: begin
                    if (r_rxd_sync) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_perr    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver) begin
                // A transfer on the delivery edge frees the register for the new word.
                if (r_valid && !rx.rx_ready) begin
                    r_overrun <= 1'b1;
                end else begin
                    r_data  <= r_shreg;
                    r_ferr  <= !r_rxd_sync;
                    r_perr  <= w_perr_word;
                    r_valid <= 1'b1;
                end
            end else if (w_xfer) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign busy          = (r_state != S_IDLE);
    assign rx.rx_data    = r_data;
    assign rx.rx_valid   = r_valid;
    assign rx.rx_ferr    = r_ferr;
    assign rx.rx_perr    = r_perr;
    assign rx.rx_overrun = r_overrun;
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame
module tb_uart_rx_frame;
    localparam int DB     = 8;
    localparam int OS     = 16;
    localparam int PODD   = 0;
    localparam int CPT    = 4;
    localparam int BITCLK = OS * CPT;
`ifdef UART_RX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif
    // os_tick index (counted from the detected start edge) of the stop-bit sample.
    localparam int STOP_TICK = OS / 2 + (DB + 1 + PBITS) * OS;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic os_tick = 1'b0;
    logic rxd = 1'b1;
    logic busy;

    uart_rx_frame_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_frame #(
        .DATA_BITS (DB),
        .OVERSAMPLE(OS),
        .PARITY_ODD(PODD)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .os_tick(os_tick),
        .rxd    (rxd),
        .busy   (busy),
        .rx     (rx_if)
    );

    always #5 clk = ~clk;

    initial begin : os_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            div = (div + 1) % CPT;
            os_tick = (div == 0);
        end
    end

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int n_tests = 0;
    int n_fail  = 0;
    int vcnt    = 0;
    int ovr_cnt = 0;
    logic [DB+1:0] got_q[$];

    // Records every completed transfer and overrun pulse seen on the output.
    always @(negedge clk) begin
        if (!reset) begin
            if (rx_if.rx_valid) vcnt <= vcnt + 1;
            if (rx_if.rx_valid && rx_if.rx_ready)
                got_q.push_back({rx_if.rx_perr, rx_if.rx_ferr, rx_if.rx_data});
            if (rx_if.rx_overrun) ovr_cnt <= ovr_cnt + 1;
        end
    end

    function automatic logic good_parity(input logic [DB-1:0] d);
        logic odd;
        odd = (PODD != 0);
        return (^d) ^ odd;
    endfunction

    function automatic logic [DB+1:0] expect_word(input logic [DB-1:0] d,
                                                  input logic stop,
                                                  input logic pbit);
        logic odd;
        logic perr;
        odd  = (PODD != 0);
        perr = (PBITS != 0) ? ((^d) ^ pbit ^ odd) : 1'b0;
        return {perr, ~stop, d};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        clks(n);
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic stop, input logic pbit);
        rxd = 1'b0;
        clks(BITCLK);
        for (int i = 0; i < DB; i++) begin
            rxd = d[i];
            clks(BITCLK);
        end
        if (PBITS != 0) begin
            rxd = pbit;
            clks(BITCLK);
        end
        rxd = stop;
        clks(BITCLK);
    endtask

    task automatic check_got(input string tag, input logic [DB+1:0] exp);
        chk({tag, "_count"}, got_q.size(), 1);
        if (got_q.size() > 0) chk(tag, got_q.pop_front(), exp);
        got_q.delete();
    endtask

    initial begin : main
        logic [DB-1:0] d;
        logic          stop;
        int            v0;
        int            o0;
        int            t;
        int            n;

        rx_if.rx_ready = 1'b0;
        clks(5);
        reset = 1'b0;
        clks(3);

        chk("reset_data", rx_if.rx_data, 0);
        chk("reset_valid", rx_if.rx_valid, 0);
        chk("reset_ferr", rx_if.rx_ferr, 0);
        chk("reset_perr", rx_if.rx_perr, 0);
        chk("reset_overrun", rx_if.rx_overrun, 0);
        chk("reset_busy", busy, 0);
        idle(BITCLK);

        // Directed 0xA5 then random words, consumer always ready.
        rx_if.rx_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            d    = (k == 0) ? 8'hA5 : DB'($urandom_range(0, 255));
            stop = (k == 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
            v0   = vcnt;
            got_q.delete();
            send_frame(d, stop, good_parity(d));
            chk("frame_busy_after_stop", busy, !stop);
            idle(BITCLK);
            check_got("frame_word", expect_word(d, stop, good_parity(d)));
            chk("frame_valid_cycles", vcnt - v0, 1);
            chk("frame_busy_idle", busy, 0);
        end

        // False start: 4 os_ticks low.
        got_q.delete();
        rxd = 1'b0;
        clks(12);
        chk("false_start_busy_hi", busy, 1);
        clks(4);
        idle(BITCLK);
        chk("false_start_busy_lo", busy, 0);
        chk("false_start_valid", rx_if.rx_valid, 0);
        chk("false_start_no_word", got_q.size(), 0);

        // Framing error followed by a held break.
        got_q.delete();
        send_frame(8'h3C, 1'b0, good_parity(8'h3C));
        clks(2 * BITCLK);
        chk("break_busy_wait", busy, 1);
        check_got("break_word", expect_word(8'h3C, 1'b0, good_parity(8'h3C)));
        idle(8);
        chk("break_busy_released", busy, 0);
        idle(2 * BITCLK);
        chk("break_no_second", got_q.size(), 0);

        // Overrun: two frames with the consumer stalled.
        rx_if.rx_ready = 1'b0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b1, good_parity(8'h11));
        send_frame(8'h22, 1'b1, good_parity(8'h22));
        idle(32);
        chk("ovr_data_kept", rx_if.rx_data, 8'h11);
        chk("ovr_valid", rx_if.rx_valid, 1);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_no_transfer", got_q.size(), 0);
        rx_if.rx_ready = 1'b1;
        clks(1);
        chk("ovr_valid_cleared", rx_if.rx_valid, 0);
        rx_if.rx_ready = 1'b0;
        check_got("ovr_consumed", expect_word(8'h11, 1'b1, good_parity(8'h11)));

        // Transfer and delivery on the same edge.
        send_frame(8'h44, 1'b1, good_parity(8'h44));
        idle(32);
        chk("same_edge_pending", rx_if.rx_data, 8'h44);
        got_q.delete();
        o0 = ovr_cnt;
        fork
            send_frame(8'h55, 1'b1, good_parity(8'h55));
            begin
                t = 0;
                while (!busy && t < 4 * BITCLK) begin
                    @(posedge clk);
                    #2;
                    t++;
                end
                chk("same_edge_detect", busy, 1);
                n = 0;
                t = 0;
                while (t < 20 * BITCLK) begin
                    if (os_tick) begin
                        n++;
                        if (n == STOP_TICK) break;
                    end
                    @(posedge clk);
                    #2;
                    t++;
                end
                chk("same_edge_found", n, STOP_TICK);
                rx_if.rx_ready = 1'b1;
                @(posedge clk);
                #2;
                rx_if.rx_ready = 1'b0;
            end
        join
        idle(32);
        check_got("same_edge_consumed", expect_word(8'h44, 1'b1, good_parity(8'h44)));
        chk("same_edge_new_data", rx_if.rx_data, 8'h55);
        chk("same_edge_valid", rx_if.rx_valid, 1);
        chk("same_edge_no_overrun", ovr_cnt - o0, 0);

        // Reset mid-DATA with a word still pending.
        rxd = 1'b0;
        clks(BITCLK);
        rxd = 1'b1;
        clks(BITCLK);
        rxd = 1'b0;
        clks(30);
        chk("rst_mid_busy", busy, 1);
        reset = 1'b1;
        clks(2);
        chk("rst_mid_data", rx_if.rx_data, 0);
        chk("rst_mid_valid", rx_if.rx_valid, 0);
        chk("rst_mid_flags", {rx_if.rx_ferr, rx_if.rx_perr, rx_if.rx_overrun}, 0);
        chk("rst_mid_busy_lo", busy, 0);
        rxd = 1'b1;
        clks(3);
        reset = 1'b0;
        idle(2 * BITCLK);
        rx_if.rx_ready = 1'b1;
        got_q.delete();
        d = DB'($urandom_range(0, 255));
        send_frame(d, 1'b1, good_parity(d));
        idle(BITCLK);
        check_got("rst_recover_word", expect_word(d, 1'b1, good_parity(d)));

`ifdef UART_RX_PARITY_EN
        got_q.delete();
        send_frame(8'h07, 1'b1, 1'b0);
        idle(BITCLK);
        check_got("parity_err_word", expect_word(8'h07, 1'b1, 1'b0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
